// File: rtl/spi_txn_sequencer.sv
// Host-side SPI transaction sequencer: frames host bytes into chip-select windows for the controller
// and returns received bytes with a last flag. Define SPI_SEQ_TIMEOUT_EN to build in the RX watchdog.
module spi_txn_sequencer #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int FIFO_DEPTH       = 8,
    localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1),
    localparam int AW              = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_wr_valid,
    output logic          host_wr_ready,
    input  logic [7:0]    host_wr_byte,
    input  logic          host_wr_last,
    output logic          host_rd_valid,
    input  logic          host_rd_ready,
    output logic [7:0]    host_rd_byte,
    output logic          host_rd_last,
    output logic [CW-1:0] controller_tx_count,
    output logic [7:0]    controller_tx_byte,
    output logic          controller_tx_dv,
    input  logic          controller_tx_ready,
    input  logic          controller_rx_dv,
    input  logic [7:0]    controller_rx_byte,
    output logic          busy,
    output logic          err_oversize,
    output logic          err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_GAP     = 2'd2,
        S_WAIT_RX = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] LEN_ZERO = CW'(0);
    localparam logic [CW-1:0] LEN_ONE  = CW'(1);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_BYTES_PER_CS);

    function automatic logic [AW:0] cnt_next(input logic [AW:0] c, input logic push, input logic pop);
        case ({push, pop})
            2'b10:   cnt_next = c + CNT_ONE;
            2'b01:   cnt_next = c - CNT_ONE;
            default: cnt_next = c;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cur_len_q, cur_len_d, txc_q, txc_d, rxc_q, rxc_d, wlen_q, wlen_d;

    logic [7:0]    tx_mem  [FIFO_DEPTH];
    logic [CW-1:0] len_mem [FIFO_DEPTH];
    logic [8:0]    rx_mem  [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] len_wp_q, len_wp_d, len_rp_q, len_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, len_cnt_q, len_cnt_d, rx_cnt_q, rx_cnt_d;

    logic          host_wr_ready_q, host_wr_ready_d, host_rd_valid_q, host_rd_valid_d;
    logic [7:0]    host_rd_byte_q, host_rd_byte_d;
    logic          host_rd_last_q, host_rd_last_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_dv_q, tx_dv_d, busy_q, busy_d, err_ov_q, err_ov_d, err_to_q, err_to_d;

    logic          wr_fire_s, close_s, tx_pop_s, len_pop_s, rx_push_s, rx_last_s, rd_pop_s;
    logic [CW-1:0] wlen_inc_s, rxc_inc_s, len_head_s;
    logic [AW:0]   rx_free_s;
    logic [8:0]    rx_entry_s;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [7:0]    wd_q, wd_d;

    // Watchdog runs only while waiting for RX; any received byte restarts it.
    always_comb begin
        wd_d = 8'd0;
        if (state_q == S_WAIT_RX && !controller_rx_dv) begin
            wd_d = wd_q + 8'd1;
        end else begin
            wd_d = 8'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Write framing, FSM, FIFO bookkeeping and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        txc_d     = txc_q;
        rxc_d     = rxc_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        err_to_d  = 1'b0;
        tx_pop_s  = 1'b0;
        len_pop_s = 1'b0;

        wr_fire_s  = host_wr_valid && host_wr_ready_q;
        wlen_inc_s = wlen_q + LEN_ONE;
        close_s    = host_wr_last || (wlen_inc_s == MAX_C);
        wlen_d     = wr_fire_s ? (close_s ? LEN_ZERO : wlen_inc_s) : wlen_q;
        err_ov_d   = wr_fire_s && close_s && !host_wr_last;

        len_head_s = len_mem[len_rp_q];
        rx_free_s  = DEPTH_C - rx_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Admit a transaction only if all its replies are guaranteed to fit.
                if (len_cnt_q != CNT_ZERO && rx_free_s >= (AW + 1)'(len_head_s)) begin
                    len_pop_s = 1'b1;
                    cur_len_d = len_head_s;
                    txc_d     = LEN_ZERO;
                    rxc_d     = LEN_ZERO;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (controller_tx_ready && tx_cnt_q != CNT_ZERO) begin
                    tx_pop_s  = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = tx_mem[tx_rp_q];
                    txc_d     = txc_q + LEN_ONE;
                    state_d   = S_GAP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                state_d = (txc_q < cur_len_q) ? S_ISSUE : S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (rxc_q == cur_len_q) begin
                    state_d = S_IDLE;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (wd_q == 8'hFF) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                end
`endif
                else begin
                    state_d = S_WAIT_RX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_pop_s  = host_rd_valid_q && host_rd_ready;
        rxc_inc_s = rxc_q + LEN_ONE;
        rx_last_s = (rxc_inc_s == cur_len_q);
        rx_push_s = controller_rx_dv && (state_q != S_IDLE) && ((rx_cnt_q != DEPTH_C) || rd_pop_s);
        if (rx_push_s) begin
            rxc_d = rxc_inc_s;
        end else begin
            rxc_d = rxc_d;
        end

        tx_wp_d   = wr_fire_s ? tx_wp_q + PTR_ONE : tx_wp_q;
        tx_rp_d   = tx_pop_s ? tx_rp_q + PTR_ONE : tx_rp_q;
        tx_cnt_d  = cnt_next(tx_cnt_q, wr_fire_s, tx_pop_s);
        len_wp_d  = (wr_fire_s && close_s) ? len_wp_q + PTR_ONE : len_wp_q;
        len_rp_d  = len_pop_s ? len_rp_q + PTR_ONE : len_rp_q;
        len_cnt_d = cnt_next(len_cnt_q, wr_fire_s && close_s, len_pop_s);
        rx_wp_d   = rx_push_s ? rx_wp_q + PTR_ONE : rx_wp_q;
        rx_rp_d   = rd_pop_s ? rx_rp_q + PTR_ONE : rx_rp_q;
        rx_cnt_d  = cnt_next(rx_cnt_q, rx_push_s, rd_pop_s);

        // The new head may be the entry written this very cycle, so forward it.
        if (rx_cnt_d == CNT_ZERO) begin
            rx_entry_s = 9'd0;
        end else if (rx_push_s && rx_wp_q == rx_rp_d) begin
            rx_entry_s = {rx_last_s, controller_rx_byte};
        end else begin
            rx_entry_s = rx_mem[rx_rp_d];
        end

        host_wr_ready_d = (tx_cnt_d != DEPTH_C) && (len_cnt_d != DEPTH_C);
        host_rd_valid_d = (rx_cnt_d != CNT_ZERO);
        host_rd_byte_d  = rx_entry_s[7:0];
        host_rd_last_d  = rx_entry_s[8];
        busy_d          = (state_d != S_IDLE);
    end

    // FIFO storage; contents are don't-care until the pointers make them visible.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            tx_mem[tx_wp_q] <= host_wr_byte;
        end
        if (wr_fire_s && close_s) begin
            len_mem[len_wp_q] <= wlen_inc_s;
        end
        if (rx_push_s) begin
            rx_mem[rx_wp_q] <= {rx_last_s, controller_rx_byte};
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cur_len_q       <= LEN_ONE;
            txc_q           <= LEN_ZERO;
            rxc_q           <= LEN_ZERO;
            wlen_q          <= LEN_ZERO;
            tx_wp_q         <= AW'(0);
            tx_rp_q         <= AW'(0);
            len_wp_q        <= AW'(0);
            len_rp_q        <= AW'(0);
            rx_wp_q         <= AW'(0);
            rx_rp_q         <= AW'(0);
            tx_cnt_q        <= CNT_ZERO;
            len_cnt_q       <= CNT_ZERO;
            rx_cnt_q        <= CNT_ZERO;
            host_wr_ready_q <= 1'b1;
            host_rd_valid_q <= 1'b0;
            host_rd_byte_q  <= 8'd0;
            host_rd_last_q  <= 1'b0;
            tx_byte_q       <= 8'd0;
            tx_dv_q         <= 1'b0;
            busy_q          <= 1'b0;
            err_ov_q        <= 1'b0;
            err_to_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_len_q       <= cur_len_d;
            txc_q           <= txc_d;
            rxc_q           <= rxc_d;
            wlen_q          <= wlen_d;
            tx_wp_q         <= tx_wp_d;
            tx_rp_q         <= tx_rp_d;
            len_wp_q        <= len_wp_d;
            len_rp_q        <= len_rp_d;
            rx_wp_q         <= rx_wp_d;
            rx_rp_q         <= rx_rp_d;
            tx_cnt_q        <= tx_cnt_d;
            len_cnt_q       <= len_cnt_d;
            rx_cnt_q        <= rx_cnt_d;
            host_wr_ready_q <= host_wr_ready_d;
            host_rd_valid_q <= host_rd_valid_d;
            host_rd_byte_q  <= host_rd_byte_d;
            host_rd_last_q  <= host_rd_last_d;
            tx_byte_q       <= tx_byte_d;
            tx_dv_q         <= tx_dv_d;
            busy_q          <= busy_d;
            err_ov_q        <= err_ov_d;
            err_to_q        <= err_to_d;
        end
    end

    assign host_wr_ready       = host_wr_ready_q;
    assign host_rd_valid       = host_rd_valid_q;
    assign host_rd_byte        = host_rd_byte_q;
    assign host_rd_last        = host_rd_last_q;
    assign controller_tx_count = cur_len_q;
    assign controller_tx_byte  = tx_byte_q;
    assign controller_tx_dv    = tx_dv_q;
    assign busy                = busy_q;
    assign err_oversize        = err_ov_q;
    assign err_timeout         = err_to_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Scoreboard bench for spi_txn_sequencer with an echoing controller model
// (each strobed byte comes back as a received byte two cycles later).
module tb_spi_txn_sequencer;
    localparam int MAXB  = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_wr_valid = 1'b0, host_wr_ready, host_wr_last = 1'b0;
    logic [7:0]    host_wr_byte = 8'd0;
    logic          host_rd_valid, host_rd_ready = 1'b1, host_rd_last;
    logic [7:0]    host_rd_byte;
    logic [CW-1:0] controller_tx_count;
    logic [7:0]    controller_tx_byte, controller_rx_byte = 8'd0;
    logic          controller_tx_dv, controller_tx_ready = 1'b1, controller_rx_dv = 1'b0;
    logic          busy, err_oversize, err_timeout;

    spi_txn_sequencer #(.MAX_BYTES_PER_CS(MAXB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_byte(host_wr_byte), .host_wr_last(host_wr_last),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
        .host_rd_byte(host_rd_byte), .host_rd_last(host_rd_last),
        .controller_tx_count(controller_tx_count), .controller_tx_byte(controller_tx_byte),
        .controller_tx_dv(controller_tx_dv), .controller_tx_ready(controller_tx_ready),
        .controller_rx_dv(controller_rx_dv), .controller_rx_byte(controller_rx_byte),
        .busy(busy), .err_oversize(err_oversize), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [7:0] exp_tx[$];
    logic [8:0] exp_rx[$];
    int         exp_len[$];
    logic [7:0] echo_q[$];
    int         echo_t[$];
    int cyc = 0, mdl_len = 0, exp_ov = 0, ov_seen = 0, to_seen = 0, tx_seen = 0;
    int tx_in_txn = 0, cur_exp_len = 0, last_dv_cyc = 0;
    bit echo_en = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Controller model and output monitor, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        controller_rx_dv = 1'b0;
        if (!rst) begin
            if (controller_tx_dv) begin
                tx_seen++;
                check_val("tx_queued", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check_val("tx_byte", controller_tx_byte, exp_tx.pop_front());
                if (tx_in_txn == 0) begin
                    check_val("len_queued", exp_len.size() != 0, 1);
                    if (exp_len.size() != 0) cur_exp_len = exp_len.pop_front();
                end else begin
                    check_val("tx_gap", (cyc - last_dv_cyc) >= 2, 1);
                end
                check_val("tx_count", controller_tx_count, cur_exp_len);
                tx_in_txn++;
                if (tx_in_txn >= cur_exp_len) tx_in_txn = 0;
                last_dv_cyc = cyc;
                if (echo_en) begin
                    echo_q.push_back(controller_tx_byte);
                    echo_t.push_back(cyc + 2);
                end
            end
            if (echo_q.size() != 0 && echo_t[0] <= cyc) begin
                controller_rx_dv   = 1'b1;
                controller_rx_byte = echo_q.pop_front();
                void'(echo_t.pop_front());
            end
            if (host_rd_valid && host_rd_ready) begin
                check_val("rx_queued", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) check_val("rx_entry", {host_rd_last, host_rd_byte}, exp_rx.pop_front());
            end
            if (err_oversize) ov_seen++;
            if (err_timeout) to_seen++;
        end
    end

    task automatic check_reset_outputs();
        check_val("rst_tx_count", controller_tx_count, 1);
        check_val("rst_tx_byte", controller_tx_byte, 0);
        check_val("rst_tx_dv", controller_tx_dv, 0);
        check_val("rst_rd_valid", host_rd_valid, 0);
        check_val("rst_rd_byte", host_rd_byte, 0);
        check_val("rst_rd_last", host_rd_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err_ov", err_oversize, 0);
        check_val("rst_err_to", err_timeout, 0);
        check_val("rst_wr_ready", host_wr_ready, 1);
    endtask

    task automatic clear_model();
        exp_tx.delete(); exp_rx.delete(); exp_len.delete();
        echo_q.delete(); echo_t.delete();
        mdl_len = 0; tx_in_txn = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one host byte; entered and left at posedge+1.
    task automatic host_write(input logic [7:0] b, input logic last);
        bit done = 1'b0;
        bit close;
        host_wr_valid = 1'b1; host_wr_byte = b; host_wr_last = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (host_wr_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        host_wr_valid = 1'b0; host_wr_last = 1'b0;
        check_val("wr_accept", done, 1);
        if (done) begin
            mdl_len++;
            close = last || (mdl_len == MAXB);
            exp_tx.push_back(b);
            if (echo_en) exp_rx.push_back({close, b});
            if (close) begin
                exp_len.push_back(mdl_len);
                if (!last) exp_ov++;
                mdl_len = 0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_rx.size() == 0 && echo_q.size() == 0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        check_val("drain", done, 1);
    endtask

    initial begin
        int tx_before;
        int to_base;
        bit got;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        // Single-byte transaction.
        host_write(8'hA5, 1'b1);
        wait_drain(100);
        check_val("t1_busy", busy, 0);
        check_val("t1_count", controller_tx_count, 1);

        // Two-byte transaction.
        host_write(8'h11, 1'b0);
        host_write(8'h22, 1'b1);
        wait_drain(100);
        check_val("t2_count", controller_tx_count, 2);

        // Forced termination at the window limit.
        host_write(8'h01, 1'b0);
        host_write(8'h02, 1'b0);
        host_write(8'h03, 1'b1);
        wait_drain(150);
        check_val("t3_oversize", ov_seen, exp_ov);
        check_val("t3_count", controller_tx_count, 1);

        // RX back-pressure: seven entries held, a length-2 transaction must wait.
        host_rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) host_write(8'h40 + 8'(i), 1'b1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && echo_q.size() == 0) got = 1'b1;
        end
        @(posedge clk); #1;
        check_val("t4_fill", got, 1);
        host_write(8'hB1, 1'b0);
        host_write(8'hB2, 1'b1);
        tx_before = tx_seen;
        repeat (20) @(negedge clk);
        check_val("t4_held_idle", busy, 0);
        check_val("t4_no_issue", tx_seen - tx_before, 0);
        check_val("t4_rd_valid", host_rd_valid, 1);
        @(posedge clk); #1 host_rd_ready = 1'b1;
        @(posedge clk); #1 host_rd_ready = 1'b0;
        repeat (20) @(negedge clk);
        check_val("t4_issued", tx_seen - tx_before, 2);
        @(posedge clk); #1 host_rd_ready = 1'b1;
        wait_drain(200);

        // RX watchdog: controller never answers.
        echo_en = 1'b0;
        to_base = to_seen;
        host_write(8'h77, 1'b1);
        repeat (300) @(negedge clk);
        check_val("t5_tx_done", exp_tx.size(), 0);
`ifdef SPI_SEQ_TIMEOUT_EN
        check_val("t5_timeout", to_seen - to_base, 1);
        check_val("t5_busy", busy, 0);
        check_val("t5_rd_valid", host_rd_valid, 0);
`else
        check_val("t5_timeout", to_seen - to_base, 0);
        check_val("t5_busy", busy, 1);
`endif
        @(posedge clk);
        pulse_reset();

        // Reset asserted while the FSM sits in GAP.
        host_write(8'hC1, 1'b0);
        host_write(8'hC2, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (controller_tx_dv) got = 1'b1;
        end
        check_val("t6_strobe", got, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_model();
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        echo_en = 1'b1;

        // Normal traffic after the reset.
        host_write(8'hD4, 1'b1);
        wait_drain(100);
        check_val("t7_count", controller_tx_count, 1);
        check_val("t7_oversize", ov_seen, exp_ov);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
